sram_march_bist: RTL and testbench



---
 rtl/sram_bist_pkg.sv | 41 ++++
 rtl/sram_bist_checker.sv | 75 +++++++
 rtl/sram_march_bist.sv | 171 +++++++++++++++++
 tb/tb_sram_march_bist.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM March C- BIST sequencer.
// Holds the FSM state enum, the march element table and the error counter width.
package sram_bist_pkg;

  localparam int unsigned FAIL_CNT_W = 16;

  typedef enum logic [3:0] {
    StIdle,
    StM0,
    StM1,
    StM2,
    StM3,
    StM4,
    StM5,
    StDrain,
    StDone
  } state_e;

  // One march element: walk direction, background polarities and which ops it issues.
  typedef struct packed {
    logic down;    // addr_max..0 instead of 0..addr_max
    logic rd_inv;  // read expects ~P
    logic wr_inv;  // write stores ~P
    logic has_rd;
    logic has_wr;
  } march_elem_t;

  // Indexed by state_e; non-march states issue no commands.
  localparam march_elem_t [8:0] MARCH_TBL = {
    5'b00000,  // StDone
    5'b00000,  // StDrain
    5'b10010,  // StM5: down, r(P)
    5'b11011,  // StM4: down, r(~P) w(P)
    5'b10111,  // StM3: down, r(P) w(~P)
    5'b01011,  // StM2: up, r(~P) w(P)
    5'b00111,  // StM1: up, r(P) w(~P)
    5'b00001,  // StM0: up, w(P)
    5'b00000   // StIdle
  };

endpackage

// File: rtl/sram_bist_checker.sv
// Read-data checker for the March BIST: delays the expected value and address of each
// read by one cycle, compares the masked macro data, captures the first failure and
// keeps a saturating mismatch count.
module sram_bist_checker
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic                  i_rd_vld,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  input  logic [DATA_W-1:0]     i_rd_exp,
  input  logic [DATA_W-1:0]     i_cmp_mask,
  input  logic [DATA_W-1:0]     i_dout0,
  output logic                  o_mismatch,
  output logic [ADDR_W-1:0]     o_fail_addr,
  output logic [DATA_W-1:0]     o_fail_data,
  output logic [FAIL_CNT_W-1:0] o_fail_count
);

  logic                  r_vld;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_exp;
  logic [ADDR_W-1:0]     r_fail_addr;
  logic [DATA_W-1:0]     r_fail_data;
  logic [FAIL_CNT_W-1:0] r_fail_count;

  // Masked compare of the data returned for the read issued one cycle earlier.
  always_comb begin
    o_mismatch = i_en && r_vld && (((i_dout0 ^ r_exp) & i_cmp_mask) != '0);
  end

  // Align read expectation with the macro's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vld  <= 1'b0;
      r_addr <= '0;
      r_exp  <= '0;
    end else begin
      r_vld  <= i_rd_vld;
      r_addr <= i_rd_addr;
      r_exp  <= i_rd_exp;
    end
  end

  // First-failure capture and saturating error count; cleared at test start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fail_addr  <= '0;
      r_fail_data  <= '0;
      r_fail_count <= '0;
    end else if (i_clear) begin
      r_fail_addr  <= '0;
      r_fail_data  <= '0;
      r_fail_count <= '0;
    end else if (o_mismatch) begin
      if (r_fail_count == '0) begin
        r_fail_addr <= r_addr;
        r_fail_data <= i_dout0;
      end
      if (r_fail_count != {FAIL_CNT_W{1'b1}}) begin
        r_fail_count <= r_fail_count + FAIL_CNT_W'(1);
      end
    end
  end

  assign o_fail_addr  = r_fail_addr;
  assign o_fail_data  = r_fail_data;
  assign o_fail_count = r_fail_count;

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST sequencer for the OpenRAM testchip macros. Drives the shared port-0 bus
// and one csb0 line, walks M0..M5, then DRAIN checks the last read before DONE.
// Optional: define SRAM_BIST_ABORT_ON_FAIL_EN to stop at the first mismatch.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WMASK_W   = 4,
  parameter int unsigned MAX_CHIPS = 16,
  parameter int unsigned CHIP_W    = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_start,
  input  logic [CHIP_W-1:0]     i_chip_sel,
  input  logic [ADDR_W-1:0]     i_addr_max,
  input  logic [DATA_W-1:0]     i_pattern,
  input  logic [DATA_W-1:0]     i_cmp_mask,
  input  logic [DATA_W-1:0]     i_dout0,
  output logic [MAX_CHIPS-1:0]  o_csb0,
  output logic                  o_web0,
  output logic [WMASK_W-1:0]    o_wmask0,
  output logic [ADDR_W-1:0]     o_addr0,
  output logic [DATA_W-1:0]     o_din0,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [ADDR_W-1:0]     o_fail_addr,
  output logic [DATA_W-1:0]     o_fail_data,
  output logic [FAIL_CNT_W-1:0] o_fail_count
);

  state_e                r_state, w_state_d;
  logic [ADDR_W-1:0]     r_addr, w_addr_d;
  logic                  r_wr, w_wr_d;
  logic [CHIP_W-1:0]     r_chip;
  logic [ADDR_W-1:0]     r_max;
  logic [DATA_W-1:0]     r_pat, r_mask;
  logic [MAX_CHIPS-1:0]  r_csb, w_csb_d;
  logic                  r_web;
  logic [WMASK_W-1:0]    r_wmask;
  logic [DATA_W-1:0]     r_din, w_din_d, r_exp, w_exp_d;
  logic                  r_rd;
  logic                  w_acc, w_last, w_cmd, w_wr_cmd, w_mismatch, w_active;
  logic [CHIP_W-1:0]     w_chip;
  logic [DATA_W-1:0]     w_pat;
  march_elem_t           w_cur, w_nxt;

  // Next command: element sequencing, address walk and the bus values it implies.
  always_comb begin
    w_acc     = i_start && ((r_state == StIdle) || (r_state == StDone));
    w_cur     = MARCH_TBL[r_state];
    w_last    = w_cur.down ? (r_addr == '0) : (r_addr == r_max);
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_wr_d    = r_wr;
    w_nxt     = '0;
    unique case (r_state)
      StIdle, StDone: begin
        if (w_acc) begin
          w_state_d = StM0;
          w_addr_d  = '0;
          w_wr_d    = 1'b1;
        end
      end
      StDrain: w_state_d = StDone;
      default: begin
        if (w_cur.has_rd && w_cur.has_wr && !r_wr) begin
          w_wr_d = 1'b1;  // write back to the address just read
        end else if (w_last) begin
          w_state_d = state_e'(r_state + 4'd1);
          w_nxt     = MARCH_TBL[w_state_d];
          w_addr_d  = w_nxt.down ? r_max : '0;
          w_wr_d    = !w_nxt.has_rd;
        end else begin
          w_addr_d = w_cur.down ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
          w_wr_d   = !w_cur.has_rd;
        end
      end
    endcase
`ifdef SRAM_BIST_ABORT_ON_FAIL_EN
    if (w_mismatch) w_state_d = StDone;
`endif
    // Config is latched on the accept edge, so use the live inputs for the first command.
    w_chip   = w_acc ? i_chip_sel : r_chip;
    w_pat    = w_acc ? i_pattern : r_pat;
    w_nxt    = MARCH_TBL[w_state_d];
    w_cmd    = w_nxt.has_rd || w_nxt.has_wr;
    w_wr_cmd = w_cmd && w_wr_d;
    w_din_d  = w_wr_cmd ? (w_nxt.wr_inv ? ~w_pat : w_pat) : '0;
    w_exp_d  = w_nxt.rd_inv ? ~w_pat : w_pat;
    w_csb_d  = '1;
    for (int unsigned i = 0; i < MAX_CHIPS; i++) begin
      if (w_cmd && ({{(32 - CHIP_W){1'b0}}, w_chip} == i)) w_csb_d[i] = 1'b0;
    end
  end

  // FSM state, address counter and registered port-0 bus.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_csb   <= '1;
      r_web   <= 1'b1;
      r_wmask <= '0;
      r_din   <= '0;
      r_rd    <= 1'b0;
      r_exp   <= '0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_wr    <= w_wr_d;
      r_csb   <= w_csb_d;
      r_web   <= !w_wr_cmd;
      r_wmask <= w_wr_cmd ? '1 : '0;
      r_din   <= w_din_d;
      r_rd    <= w_cmd && !w_wr_d;
      r_exp   <= w_exp_d;
    end
  end

  // Test configuration captured when start is accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_chip <= '0;
      r_max  <= '0;
      r_pat  <= '0;
      r_mask <= '0;
    end else if (w_acc) begin
      r_chip <= i_chip_sel;
      r_max  <= i_addr_max;
      r_pat  <= i_pattern;
      r_mask <= i_cmp_mask;
    end
  end

  // Compares are only meaningful while a test runs; a read left in flight by an abort
  // lands in DONE and is ignored.
  assign w_active = (r_state != StIdle) && (r_state != StDone);

  sram_bist_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_checker (
    .clk         (clk),
    .resetn      (resetn),
    .i_clear     (w_acc),
    .i_en        (w_active),
    .i_rd_vld    (r_rd),
    .i_rd_addr   (r_addr),
    .i_rd_exp    (r_exp),
    .i_cmp_mask  (r_mask),
    .i_dout0     (i_dout0),
    .o_mismatch  (w_mismatch),
    .o_fail_addr (o_fail_addr),
    .o_fail_data (o_fail_data),
    .o_fail_count(o_fail_count)
  );

  assign o_csb0   = r_csb;
  assign o_web0   = r_web;
  assign o_wmask0 = r_wmask;
  assign o_addr0  = r_addr;
  assign o_din0   = r_din;
  assign o_busy   = w_active;
  assign o_done   = (r_state == StDone);
  assign o_pass   = o_done && (o_fail_count == '0);

endmodule

// File: tb/tb_sram_march_bist.sv
// Self-checking bench for sram_march_bist: table of test vectors, an SRAM model with
// optional stuck-at bit / 8-bit width, and a scoreboard of expected bus commands.
module tb_sram_march_bist;

  logic        clk        = 1'b0;
  logic        resetn     = 1'b0;
  logic        i_start    = 1'b0;
  logic [3:0]  i_chip_sel = '0;
  logic [15:0] i_addr_max = '0;
  logic [31:0] i_pattern  = '0;
  logic [31:0] i_cmp_mask = '0;
  logic [31:0] i_dout0    = '0;
  logic [15:0] o_csb0;
  logic        o_web0;
  logic [3:0]  o_wmask0;
  logic [15:0] o_addr0;
  logic [31:0] o_din0;
  logic        o_busy, o_done, o_pass;
  logic [15:0] o_fail_addr;
  logic [31:0] o_fail_data;
  logic [15:0] o_fail_count;

  always #5 clk = ~clk;

  sram_march_bist dut (
    .clk(clk), .resetn(resetn), .i_start(i_start), .i_chip_sel(i_chip_sel),
    .i_addr_max(i_addr_max), .i_pattern(i_pattern), .i_cmp_mask(i_cmp_mask),
    .i_dout0(i_dout0), .o_csb0(o_csb0), .o_web0(o_web0), .o_wmask0(o_wmask0),
    .o_addr0(o_addr0), .o_din0(o_din0), .o_busy(o_busy), .o_done(o_done),
    .o_pass(o_pass), .o_fail_addr(o_fail_addr), .o_fail_data(o_fail_data),
    .o_fail_count(o_fail_count)
  );

  typedef struct {
    logic [15:0] csb;
    logic        web;
    logic [3:0]  wmask;
    logic [15:0] addr;
    logic [31:0] din;
  } cmd_t;

  typedef struct {
    logic [3:0]  chip;
    logic [15:0] amax;
    logic [31:0] pat;
    logic [31:0] mask;
    logic [15:0] faddr;   // stuck-at-0 address (0xFFFF: none)
    int          fbit;
    bit          w8;      // 8-bit macro, random upper dout bits
    bit          any_fail;  // only "some failure" is predictable
    bit          exp_pass;
    int          exp_cyc;
  } vec_t;

  // March C- element table: bit e describes element Me.
  localparam bit [5:0] E_DN = 6'b111000;
  localparam bit [5:0] E_RI = 6'b010100;
  localparam bit [5:0] E_WI = 6'b001010;
  localparam bit [5:0] E_HR = 6'b111110;
  localparam bit [5:0] E_HW = 6'b011111;

  cmd_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          seq_err = 0;
  logic [31:0] mem [256];
  bit          w8 = 1'b0;
  logic [15:0] f_addr = 16'hFFFF;
  logic [31:0] f_mask = '0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_data = '0;
  bit          abort_build = 1'b0;
  int          p_cnt, p_cyc;
  logic [15:0] p_faddr;
  logic [31:0] p_fdata;
  vec_t        vecs[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // SRAM model and scoreboard: command seen at negedge k-1/2 is sampled at edge k;
  // read data is presented from the following negedge until the next one.
  always @(negedge clk) begin : sram_model
    cmd_t c;
    if (rd_pend) i_dout0 <= rd_data;
    rd_pend <= 1'b0;
    if ((o_csb0 != 16'hFFFF) || !o_web0) begin
      if (exp_q.size() == 0) begin
        seq_err <= seq_err + 1;
      end else begin
        c = exp_q.pop_front();
        if ((o_csb0 !== c.csb) || (o_web0 !== c.web) || (o_wmask0 !== c.wmask) ||
            (o_addr0 !== c.addr) || (!c.web && (o_din0 !== c.din)))
          seq_err <= seq_err + 1;
      end
      if (!o_web0) begin
        mem[o_addr0[7:0]] <= (w8 ? (o_din0 & 32'hFF) : o_din0) &
                             ~((o_addr0 == f_addr) ? f_mask : 32'h0);
      end else begin
        rd_pend <= 1'b1;
        rd_data <= w8 ? {24'($urandom()), mem[o_addr0[7:0]][7:0]} : mem[o_addr0[7:0]];
      end
    end
  end

  // Build the expected command stream and failure prediction, then issue start.
  task automatic launch(input vec_t v);
    cmd_t        c;
    int          n, nc, first_nc;
    logic [15:0] a;
    logic [31:0] e, got;
    exp_q.delete();
    p_cnt = 0; p_faddr = '0; p_fdata = '0; nc = 0; first_nc = 0;
    n = int'(v.amax) + 1;
    p_cyc = v.exp_cyc;
    for (int el = 0; el < 6; el++) begin
      for (int i = 0; i < n; i++) begin
        a = E_DN[el] ? (v.amax - 16'(i)) : 16'(i);
        c.csb = ~(16'h1 << v.chip);
        c.addr = a;
        if (E_HR[el]) begin
          e = E_RI[el] ? ~v.pat : v.pat;
          c.web = 1'b1; c.wmask = 4'h0; c.din = '0;
          exp_q.push_back(c);
          nc++;
          got = (a == v.faddr) ? (e & ~(32'h1 << v.fbit)) : e;
          if (!v.w8 && (((got ^ e) & v.mask) != 0)) begin
            if (p_cnt == 0) begin p_faddr = a; p_fdata = got; first_nc = nc; end
            p_cnt++;
          end
        end
        if (E_HW[el]) begin
          c.web = 1'b0; c.wmask = 4'hF; c.din = E_WI[el] ? ~v.pat : v.pat;
          exp_q.push_back(c);
          nc++;
        end
      end
    end
    if (abort_build && (p_cnt > 0)) begin
      while (exp_q.size() > first_nc + 1) void'(exp_q.pop_back());
      p_cnt = 1;
      p_cyc = first_nc + 1;
    end
    w8 = v.w8; f_addr = v.faddr; f_mask = 32'h1 << v.fbit;
    i_chip_sel = v.chip; i_addr_max = v.amax; i_pattern = v.pat; i_cmp_mask = v.mask;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    // Inputs are latched at start; scramble them to prove it.
    i_chip_sel = v.chip + 4'd1; i_pattern = ~v.pat; i_cmp_mask = ~v.mask;
    i_addr_max = v.amax + 16'd3;
  endtask

  task automatic run_vec(input vec_t v, input bit pulse, input string tag);
    int cyc, base;
    base = seq_err;
    launch(v);
    cyc = 0;
    while (!o_done && (cyc < 30000)) begin
      @(negedge clk);
      cyc++;
      i_start = pulse && ((cyc == 100) || (cyc == 200));
    end
    i_start = 1'b0;
    if (!(v.any_fail && abort_build)) check({tag, "_cycles"}, 64'(cyc), 64'(p_cyc));
    check({tag, "_done"}, 64'(o_done), 64'd1);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_pass"}, 64'(o_pass), 64'(v.exp_pass));
    if (v.any_fail) begin
      check({tag, "_cnt_nz"}, 64'(o_fail_count != 0), 64'd1);
    end else begin
      check({tag, "_cnt"}, 64'(o_fail_count), 64'(p_cnt));
      check({tag, "_faddr"}, 64'(o_fail_addr), 64'(p_faddr));
      check({tag, "_fdata"}, 64'(o_fail_data), 64'(p_fdata));
      check({tag, "_bus_seq"}, 64'(seq_err - base), 64'd0);
      check({tag, "_bus_left"}, 64'(exp_q.size()), 64'd0);
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_hold"}, 64'({o_done, o_pass}), 64'({1'b1, v.exp_pass}));
  endtask

  initial begin
`ifdef SRAM_BIST_ABORT_ON_FAIL_EN
    abort_build = 1'b1;
`endif
    //          chip   amax    pattern       cmp_mask      faddr    bit w8 any pass cycles
    vecs[0] = '{4'd1,  16'd255, 32'hA5A5A5A5, 32'hFFFFFFFF, 16'hFFFF, 0, 0, 0, 1, 2561};
    vecs[1] = '{4'd1,  16'd255, 32'hA5A5A5A5, 32'hFFFFFFFF, 16'h0010, 3, 0, 0, 0, 2561};
    vecs[2] = '{4'd3,  16'd63,  32'h0000003C, 32'h000000FF, 16'hFFFF, 0, 1, 0, 1, 641};
    vecs[3] = '{4'd3,  16'd63,  32'h0000003C, 32'hFFFFFFFF, 16'hFFFF, 0, 1, 1, 0, 641};
    vecs[4] = '{4'd0,  16'd0,   32'h12345678, 32'hFFFFFFFF, 16'hFFFF, 0, 0, 0, 1, 11};
    vecs[5] = '{4'd15, 16'd7,   32'hFFFF0000, 32'hFFFFFFFF, 16'h0005, 20, 0, 0, 0, 81};

    @(posedge clk);
    @(negedge clk);
    check("rst_csb", 64'(o_csb0), 64'hFFFF);
    check("rst_web", 64'(o_web0), 64'd1);
    check("rst_wmask", 64'(o_wmask0), 64'd0);
    check("rst_addr", 64'(o_addr0), 64'd0);
    check("rst_din", 64'(o_din0), 64'd0);
    check("rst_flags", 64'({o_busy, o_done, o_pass}), 64'd0);
    check("rst_fail", 64'({o_fail_addr, o_fail_data, o_fail_count}), 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, $sformatf("v%0d", i));

    // Reset mid-test aborts on the very edge it is sampled.
    launch(vecs[0]);
    repeat (500) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_csb", 64'(o_csb0), 64'hFFFF);
    check("abort_web", 64'(o_web0), 64'd1);
    check("abort_flags", 64'({o_busy, o_done, o_pass}), 64'd0);
    check("abort_cnt", 64'(o_fail_count), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();

    // Clean rerun with stray start pulses while busy.
    run_vec(vecs[0], 1'b1, "rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
